// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared types for the Wishbone round-robin arbiter
package wb_arbiter_pkg;

  // Arbiter phases: pick an owner, serve its bus cycle, then one dead cycle
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// rtl/wb_arbiter_rr_picker.sv - combinational round-robin requester selection
module wb_arbiter_rr_picker #(
  parameter int NB_PORTS = 2,
  parameter int IW       = 1
) (
  input  logic [NB_PORTS-1:0] req,
  input  logic [IW-1:0]       last,
  output logic                valid,
  output logic [IW-1:0]       idx
);

  // Scan from the farthest candidate down to last+1 so the closest requester
  // after the previous winner is the one left standing.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NB_PORTS; i >= 1; i--) begin
      int c;
      c = (int'(last) + i) % NB_PORTS;
      if (req[c]) begin
        valid = 1'b1;
        idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin arbiter sharing one pipelined Wishbone master port
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NB_PORTS        = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NB_PORTS*32-1:0] s_wb_adr_i,
  output logic [NB_PORTS*32-1:0] s_wb_dat_o,
  input  logic [NB_PORTS*32-1:0] s_wb_dat_i,
  input  logic [NB_PORTS-1:0]    s_wb_we_i,
  input  logic [NB_PORTS*4-1:0]  s_wb_sel_i,
  input  logic [NB_PORTS-1:0]    s_wb_stb_i,
  output logic [NB_PORTS-1:0]    s_wb_ack_o,
  input  logic [NB_PORTS-1:0]    s_wb_cyc_i,
  output logic [NB_PORTS-1:0]    s_wb_stall_o,
  output logic [31:0]            m_wb_adr_o,
  input  logic [31:0]            m_wb_dat_i,
  output logic [31:0]            m_wb_dat_o,
  output logic                   m_wb_we_o,
  output logic [3:0]             m_wb_sel_o,
  output logic                   m_wb_stb_o,
  input  logic                   m_wb_ack_i,
  output logic                   m_wb_cyc_o,
  input  logic                   m_wb_stall_i
);

  localparam int IW = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NB_PORTS - 1);
  localparam logic [OW-1:0] OUT_CAP  = OW'(MAX_OUTSTANDING);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [IW-1:0]       last_q, last_d;
  logic [OW-1:0]       outst_q, outst_d;
  logic [NB_PORTS-1:0] req;
  logic                pick_valid;
  logic [IW-1:0]       pick_idx;
  logic [31:0]         g_idx;
  logic                capped;
  logic                accept;
  logic                ack_dec;

  assign req     = s_wb_cyc_i & s_wb_stb_i;
  assign g_idx   = 32'(grant_q);
  assign capped  = (outst_q == OUT_CAP);
  assign accept  = m_wb_stb_o & ~m_wb_stall_i;
  // An ack with nothing in flight is passed through but does not underflow
  assign ack_dec = m_wb_ack_i & (outst_q != '0);

  wb_arbiter_rr_picker #(
    .NB_PORTS (NB_PORTS),
    .IW       (IW)
  ) u_picker (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // State, owner, round-robin pointer and in-flight counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      outst_q <= outst_d;
    end
  end

  // Next-state: arbitrate in IDLE, track in-flight requests in GRANT, one dead cycle in DRAIN
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    outst_d = outst_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          last_d  = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!s_wb_cyc_i[grant_q]) begin
          // Owner ended its cycle; anything still in flight is abandoned
          state_d = DRAIN;
          outst_d = '0;
        end else if (accept && !ack_dec) begin
          outst_d = outst_q + 1'b1;
        end else if (ack_dec && !accept) begin
          outst_d = outst_q - 1'b1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus routing: only the owner in GRANT sees the shared port, everyone else is held off
  always_comb begin
    m_wb_adr_o   = '0;
    m_wb_dat_o   = '0;
    m_wb_we_o    = 1'b0;
    m_wb_sel_o   = '0;
    m_wb_stb_o   = 1'b0;
    m_wb_cyc_o   = 1'b0;
    s_wb_stall_o = '1;
    s_wb_ack_o   = '0;
    s_wb_dat_o   = '0;
    if (state_q == GRANT) begin
      m_wb_adr_o                  = s_wb_adr_i[g_idx*32 +: 32];
      m_wb_dat_o                  = s_wb_dat_i[g_idx*32 +: 32];
      m_wb_we_o                   = s_wb_we_i[grant_q];
      m_wb_sel_o                  = s_wb_sel_i[g_idx*4 +: 4];
      m_wb_stb_o                  = s_wb_stb_i[grant_q] & ~capped;
      m_wb_cyc_o                  = s_wb_cyc_i[grant_q];
      s_wb_stall_o[grant_q]       = m_wb_stall_i | capped;
      s_wb_ack_o[grant_q]         = m_wb_ack_i;
      s_wb_dat_o[g_idx*32 +: 32]  = m_wb_dat_i;
    end
  end

endmodule
